counter_cycle_scheduler: RTL and testbench
==========================================

Name: counter_cycle_scheduler

Overview:
- Sequences AGC-style involuntary counter updates (PINC/MINC) into the shared 15-bit erasable memory port.
- Steals 3-cycle read-modify-write slots from the control unit at instruction boundaries.
- Applies ones' complement increment/decrement to counter cells and flags overflow.
- Sits between the control unit's memory request path and the memory model; peripherals drive counter pulses.

Parameters:
NUM_CTR, 8, number of counter cells (indices 0..NUM_CTR-1)
ADDR_W, 12, memory address width
DATA_W, 15, memory word width
CTR_BASE, 12'o0024, address of counter 0; counter i lives at CTR_BASE+i

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pinc_req  in  NUM_CTR  one-cycle pulse per counter: request +1
minc_req  in  NUM_CTR  one-cycle pulse per counter: request -1
slot_ok  in  1  high for one cycle at the control unit's instruction boundary
cpu_we  in  1  control unit write enable
cpu_addr  in  ADDR_W  control unit address
cpu_wdata  in  DATA_W  control unit write data
cpu_grant  out  1  high when the control unit owns the memory port
mem_we  out  1  to memory write enable
mem_addr  out  ADDR_W  to memory address
mem_wdata  out  DATA_W  to memory write data
mem_rdata  in  DATA_W  from memory, valid the cycle after the address is presented
ovf_irq  out  1  one-cycle pulse on counter overflow
ovf_idx  out  clog2(NUM_CTR)  index of the overflowing counter, held until the next overflow
lost  out  1  sticky: a pulse was dropped; cleared only by reset

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE; all pending bits cleared; RR pointer = 0.
  - ovf_irq = 0, ovf_idx = 0, lost = 0.
  - mem_we is forced 0 at once, so a write in flight is aborted.
- Pending store: per counter, pend_v and pend_dir (1 = PINC), updated each cycle.
  - pinc and minc together in the same cycle: no change.
  - New pulse with pend_v = 0: set pend_v and pend_dir.
  - New pulse opposite to the pending direction: clear pend_v (the two cancel).
  - New pulse in the same direction as pending: drop it and set lost.
  - The counter currently being serviced has its pend_v cleared on entry to RD. A pulse arriving in that same cycle is applied after the clear and becomes a new pending request.
- FSM states: IDLE -> RD -> CAP -> WR -> IDLE.
  - IDLE: cpu_grant = 1; mem_we/addr/wdata pass through cpu_* combinationally.
  - IDLE exit: if slot_ok and any pend_v, pick the first pending index at or after the RR pointer (wrapping), latch index and direction, go to RD.
  - RD: cpu_grant = 0; mem_addr = CTR_BASE + idx; mem_we = 0.
  - CAP: cpu_grant = 0; mem_addr is held; mem_rdata is latched into val.
  - WR: cpu_grant = 0; mem_addr is held; mem_we = 1; mem_wdata = result. RR pointer <- idx+1 mod NUM_CTR. Go to IDLE.
- Only one counter is serviced per slot_ok. slot_ok is ignored outside IDLE.
- Latency: a pulse with slot_ok already asserted gives a write 3 cycles after slot_ok.
- Ones' complement arithmetic (15-bit; +0 = 0o00000, -0 = 0o77777):
  - PINC, val = 0o37777: result 0o00000, overflow.
  - PINC, val = 0o77777: result 0o00001.
  - PINC, otherwise: result val+1.
  - MINC, val = 0o40000: result 0o77777, overflow.
  - MINC, val = 0o00000: result 0o77776.
  - MINC, otherwise: result val-1.
- Overflow: ovf_irq pulses in the WR cycle and ovf_idx <- idx. The write still occurs.

Decomposition:
- Shared package agc_pkg:
  - DATA_W/ADDR_W constants.
  - Ones' complement constants POS_MAX = 0o37777, NEG_MAX = 0o40000, NEG_ZERO = 0o77777.
  - FSM state enum.
- Sub-module oc_incdec: purely combinational; inputs val and dir, outputs result and ovf. Shared later with the adder path.

Test Plan:
- pinc_req[2] pulse, cell 0o0026 = 0o00005, slot_ok -> RD addr 0o0026, WR writes 0o00006; cpu_grant low exactly 3 cycles; ovf_irq = 0.
- minc_req[0] with cell 0o0024 = 0o40000 -> writes 0o77777; ovf_irq 1 cycle; ovf_idx = 0. pinc_req[1] with cell = 0o37777 -> writes 0o00000; ovf_idx = 1.
- pinc_req[3] then minc_req[3] before slot_ok -> no memory cycle on slot_ok. Two pinc_req[3] -> one write of +1 and lost = 1.
- pinc_req on counters 1, 4, 6 all pending; slot_ok three times -> serviced in order 1, 4, 6; then RR pointer = 7.
- rst_n low during WR -> mem_we drops asynchronously; cell unchanged; pending cleared; cpu_grant = 1 after release.

Source files
------------

// File: rtl/agc_pkg.sv
// -----------------------------------------------------------------------------
// agc_pkg
// Shared definitions for the AGC-style counter cycle scheduler:
//   - memory bus widths
//   - 15-bit ones' complement boundary constants
//   - scheduler FSM state encoding
// -----------------------------------------------------------------------------
package agc_pkg;

  localparam int DATA_W = 15;
  localparam int ADDR_W = 12;

  // Ones' complement landmarks: largest positive, most negative, and the two zeros.
  localparam logic [DATA_W-1:0] POS_ZERO = 15'o00000;
  localparam logic [DATA_W-1:0] POS_MAX  = 15'o37777;
  localparam logic [DATA_W-1:0] NEG_MAX  = 15'o40000;
  localparam logic [DATA_W-1:0] NEG_ZERO = 15'o77777;

  // One stolen read-modify-write slot: read address, capture data, write back.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } sched_state_e;

endpackage : agc_pkg

// File: rtl/counter_cycle_scheduler_if.sv
// -----------------------------------------------------------------------------
// counter_cycle_scheduler_if
// Memory request path between the control unit, the counter cycle scheduler
// and the erasable memory.
//   cpu_we/cpu_addr/cpu_wdata : control unit request
//   cpu_grant                 : control unit currently owns the memory port
//   mem_we/mem_addr/mem_wdata : request presented to memory
//   mem_rdata                 : memory read data, one cycle after the address
// Modports:
//   slave  : the scheduler (sits in the path)
//   master : the surroundings (control unit + memory)
// -----------------------------------------------------------------------------
interface counter_cycle_scheduler_if;
  import agc_pkg::*;

  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_grant;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_grant, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_grant, mem_we, mem_addr, mem_wdata
  );

endinterface : counter_cycle_scheduler_if

// File: rtl/oc_incdec.sv
// -----------------------------------------------------------------------------
// oc_incdec
// Purely combinational 15-bit ones' complement increment / decrement.
//   val    : operand
//   dir    : 1 = increment (PINC), 0 = decrement (MINC)
//   result : val +/- 1 in ones' complement
//   ovf    : the step crossed the positive/negative limit
// -----------------------------------------------------------------------------
module oc_incdec
  import agc_pkg::*;
(
  input  logic [DATA_W-1:0] val,
  input  logic              dir,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    result = val;
    ovf    = 1'b0;
    if (dir) begin
      if (val == POS_MAX) begin
        result = POS_ZERO;
        ovf    = 1'b1;
      end else if (val == NEG_ZERO) begin
        // -0 steps straight to +1, skipping +0.
        result = 15'o00001;
      end else begin
        result = val + DATA_W'(1);
      end
    end else begin
      if (val == NEG_MAX) begin
        result = NEG_ZERO;
        ovf    = 1'b1;
      end else if (val == POS_ZERO) begin
        // +0 steps straight to -1, skipping -0.
        result = 15'o77776;
      end else begin
        result = val - DATA_W'(1);
      end
    end
  end

endmodule : oc_incdec

// File: rtl/counter_cycle_scheduler.sv
// -----------------------------------------------------------------------------
// counter_cycle_scheduler
// Collects PINC/MINC pulses per counter cell and, at control unit instruction
// boundaries, steals a 3-cycle read-modify-write slot on the shared memory port
// to apply a ones' complement +/-1 to one pending counter (round robin).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   pinc_req/minc_req : per-counter one-cycle +1 / -1 request pulses
//   slot_ok           : one-cycle instruction boundary strobe
//   bus (slave)       : control unit request in, memory request out
//   ovf_irq           : one-cycle pulse when a counter overflows (WR cycle)
//   ovf_idx           : index of the last overflowing counter
//   lost              : sticky, a pulse was dropped
// -----------------------------------------------------------------------------
module counter_cycle_scheduler
  import agc_pkg::*;
#(
  parameter  int                NUM_CTR  = 8,
  parameter  logic [ADDR_W-1:0] CTR_BASE = 12'o0024,
  localparam int                IDX_W    = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CTR-1:0] pinc_req,
  input  logic [NUM_CTR-1:0] minc_req,
  input  logic               slot_ok,
  counter_cycle_scheduler_if.slave bus,
  output logic               ovf_irq,
  output logic [IDX_W-1:0]   ovf_idx,
  output logic               lost
);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [NUM_CTR-1:0] pend_v_q, pend_v_d;
  logic [NUM_CTR-1:0] pend_dir_q, pend_dir_d;
  logic              lost_q, lost_d;
  logic [IDX_W-1:0]  ovf_idx_q, ovf_idx_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              start_svc;
  logic [DATA_W-1:0] res;
  logic              res_ovf;
  logic [ADDR_W-1:0] ctr_addr;

  oc_incdec u_incdec (
    .val    (val_q),
    .dir    (dir_q),
    .result (res),
    .ovf    (res_ovf)
  );

  // First pending counter at or after the round-robin pointer, wrapping.
  // Scanning from the far end lets the nearest hit overwrite the others.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_CTR - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NUM_CTR) j = j - NUM_CTR;
      if (pend_v_q[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  assign start_svc = (state_q == ST_IDLE) && slot_ok && pick_found;

  // Pending store: the serviced counter is cleared first, then this cycle's
  // pulse is folded in, so a pulse racing the service becomes a new request.
  always_comb begin
    logic v;
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    lost_d     = lost_q;
    for (int i = 0; i < NUM_CTR; i++) begin
      v = pend_v_q[i] && !(start_svc && (pick_idx == IDX_W'(i)));
      pend_v_d[i] = v;
      if (pinc_req[i] ^ minc_req[i]) begin
        if (!v) begin
          pend_v_d[i]   = 1'b1;
          pend_dir_d[i] = pinc_req[i];
        end else if (pend_dir_q[i] != pinc_req[i]) begin
          pend_v_d[i] = 1'b0;
        end else begin
          lost_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    val_d     = val_q;
    rr_d      = rr_q;
    ovf_idx_d = ovf_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_svc) begin
          idx_d   = pick_idx;
          dir_d   = pend_dir_q[pick_idx];
          state_d = ST_RD;
        end
      end
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        val_d   = bus.mem_rdata;
        state_d = ST_WR;
      end
      ST_WR: begin
        rr_d = (idx_q == IDX_W'(NUM_CTR - 1)) ? '0 : IDX_W'(idx_q + 1'b1);
        if (res_ovf) ovf_idx_d = idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      dir_q      <= 1'b0;
      val_q      <= '0;
      rr_q       <= '0;
      pend_v_q   <= '0;
      pend_dir_q <= '0;
      lost_q     <= 1'b0;
      ovf_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      val_q      <= val_d;
      rr_q       <= rr_d;
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
      lost_q     <= lost_d;
      ovf_idx_q  <= ovf_idx_d;
    end
  end

  assign ctr_addr = CTR_BASE + ADDR_W'(idx_q);

  // Memory port mux. mem_we is gated by rst_n so a write in flight is killed
  // the moment reset asserts, without waiting for a clock edge.
  assign bus.cpu_grant = (state_q == ST_IDLE);
  assign bus.mem_we    = rst_n && ((state_q == ST_IDLE) ? bus.cpu_we : (state_q == ST_WR));
  assign bus.mem_addr  = (state_q == ST_IDLE) ? bus.cpu_addr  : ctr_addr;
  assign bus.mem_wdata = (state_q == ST_IDLE) ? bus.cpu_wdata : res;

  assign ovf_irq = (state_q == ST_WR) && res_ovf;
  assign ovf_idx = ovf_idx_q;
  assign lost    = lost_q;

endmodule : counter_cycle_scheduler

// File: tb/tb_counter_cycle_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_cycle_scheduler
// Self-checking bench: a registered memory model sits behind the scheduler,
// expected counter writes are queued as pulses are driven and compared when
// the scheduler presents its write.
// -----------------------------------------------------------------------------
module tb_counter_cycle_scheduler;
  import agc_pkg::*;

  localparam int NUM_CTR = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ovf;
  } exp_wr_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_CTR-1:0] pinc_req;
  logic [NUM_CTR-1:0] minc_req;
  logic               slot_ok;
  logic               ovf_irq;
  logic [2:0]         ovf_idx;
  logic               lost;

  counter_cycle_scheduler_if bus ();

  counter_cycle_scheduler #(
    .NUM_CTR  (NUM_CTR),
    .CTR_BASE (12'o0024)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pinc_req (pinc_req),
    .minc_req (minc_req),
    .slot_ok  (slot_ok),
    .bus      (bus),
    .ovf_irq  (ovf_irq),
    .ovf_idx  (ovf_idx),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, read data registered one cycle after address.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int      n_total = 0;
  int      n_bad   = 0;
  exp_wr_t sb_q[$];
  exp_wr_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every counter write the scheduler presents is matched
  // against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we && !bus.cpu_grant) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wr", 32'(bus.mem_addr), 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        check("wr_data", 32'(bus.mem_wdata), 32'(mon_e.data));
        check("wr_ovf", 32'(ovf_irq), 32'(mon_e.ovf));
      end
    end
  end

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic o);
    exp_wr_t e;
    e.addr = a;
    e.data = d;
    e.ovf  = o;
    sb_q.push_back(e);
  endtask

  task automatic pulse(input logic [NUM_CTR-1:0] p, input logic [NUM_CTR-1:0] m);
    @(posedge clk); #1;
    pinc_req = p;
    minc_req = m;
    @(posedge clk); #1;
    pinc_req = '0;
    minc_req = '0;
  endtask

  task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    @(posedge clk); #1;
    bus.cpu_we    = 1'b0;
  endtask

  task automatic cpu_rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    bus.cpu_addr = a;
    @(posedge clk); #1;
    d = bus.mem_rdata;
  endtask

  // One slot_ok strobe, then observe a bounded window of five cycles.
  task automatic run_slot(output int grant_low, output int irq_hi, output logic [ADDR_W-1:0] rd_addr);
    @(posedge clk); #1;
    slot_ok = 1'b1;
    @(posedge clk); #1;
    slot_ok   = 1'b0;
    grant_low = 0;
    irq_hi    = 0;
    rd_addr   = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) rd_addr = bus.mem_addr;
      if (!bus.cpu_grant) grant_low++;
      if (ovf_irq) irq_hi++;
    end
  endtask

  initial begin
    int                gl;
    int                ih;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    rst_n         = 1'b0;
    pinc_req      = '0;
    minc_req      = '0;
    slot_ok       = 1'b0;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 12'o0100;
    bus.cpu_wdata = 15'o12345;

    // Reset state, with a CPU write request held active.
    #12;
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_grant", 32'(bus.cpu_grant), 32'h1);
    check("rst_ovf_irq", 32'(ovf_irq), 32'h0);
    check("rst_ovf_idx", 32'(ovf_idx), 32'h0);
    check("rst_lost", 32'(lost), 32'h0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("pass_we", 32'(bus.mem_we), 32'h1);
    check("pass_addr", 32'(bus.mem_addr), 32'o0100);
    check("pass_wdata", 32'(bus.mem_wdata), 32'o12345);
    @(posedge clk); #1;
    bus.cpu_we = 1'b0;
    cpu_rd(12'o0100, rd);
    check("pass_rd", 32'(rd), 32'o12345);

    // Preload counter cells through the CPU path.
    cpu_wr(12'o0026, 15'o00005);
    cpu_wr(12'o0024, 15'o40000);
    cpu_wr(12'o0025, 15'o37777);
    cpu_wr(12'o0027, 15'o00010);
    cpu_wr(12'o0030, 15'o00144);
    cpu_wr(12'o0031, 15'o00070);
    cpu_wr(12'o0032, 15'o77776);
    cpu_wr(12'o0033, 15'o77777);

    // Basic PINC on counter 2.
    pulse(8'h04, 8'h00);
    expect_wr(12'o0026, 15'o00006, 1'b0);
    run_slot(gl, ih, ra);
    check("t1_rd_addr", 32'(ra), 32'o0026);
    check("t1_grant_low", 32'(gl), 32'd3);
    check("t1_irq", 32'(ih), 32'd0);
    cpu_rd(12'o0026, rd);
    check("t1_cell", 32'(rd), 32'o00006);

    // Overflow in both directions.
    pulse(8'h00, 8'h01);
    expect_wr(12'o0024, 15'o77777, 1'b1);
    run_slot(gl, ih, ra);
    check("t2_irq_cycles", 32'(ih), 32'd1);
    check("t2_ovf_idx0", 32'(ovf_idx), 32'd0);
    pulse(8'h02, 8'h00);
    expect_wr(12'o0025, 15'o00000, 1'b1);
    run_slot(gl, ih, ra);
    check("t2_irq_cycles_b", 32'(ih), 32'd1);
    check("t2_ovf_idx1", 32'(ovf_idx), 32'd1);

    // Cancellation, simultaneous pulses, dropped pulse.
    pulse(8'h08, 8'h00);
    pulse(8'h00, 8'h08);
    run_slot(gl, ih, ra);
    check("t3_cancel_grant_low", 32'(gl), 32'd0);
    pulse(8'h20, 8'h20);
    run_slot(gl, ih, ra);
    check("t3_both_grant_low", 32'(gl), 32'd0);
    check("t3_lost_before", 32'(lost), 32'h0);
    pulse(8'h08, 8'h00);
    pulse(8'h08, 8'h00);
    check("t3_lost_after", 32'(lost), 32'h1);
    expect_wr(12'o0027, 15'o00011, 1'b0);
    run_slot(gl, ih, ra);
    check("t3_single_grant_low", 32'(gl), 32'd3);

    // PINC on -0 gives +1; servicing the last counter wraps the pointer to 0.
    pulse(8'h80, 8'h00);
    expect_wr(12'o0033, 15'o00001, 1'b0);
    run_slot(gl, ih, ra);
    check("t4_ovf_idx_held", 32'(ovf_idx), 32'd1);

    // Round robin: 1, 4, 6, leaving the pointer at 7.
    pulse(8'h52, 8'h00);
    expect_wr(12'o0025, 15'o00001, 1'b0);
    expect_wr(12'o0030, 15'o00145, 1'b0);
    expect_wr(12'o0032, 15'o77777, 1'b0);
    run_slot(gl, ih, ra);
    run_slot(gl, ih, ra);
    run_slot(gl, ih, ra);
    check("t4_sb_drained", 32'(sb_q.size()), 32'd0);

    // Pointer at 7: counter 7 goes before counter 0; MINC on +0 gives -1.
    cpu_wr(12'o0024, 15'o00000);
    pulse(8'h00, 8'h81);
    expect_wr(12'o0033, 15'o00000, 1'b0);
    expect_wr(12'o0024, 15'o77776, 1'b0);
    run_slot(gl, ih, ra);
    run_slot(gl, ih, ra);

    // Reset in the middle of the write cycle for counter 5; counter 0 left pending.
    pulse(8'h21, 8'h00);
    expect_wr(12'o0031, 15'o00071, 1'b0);
    @(posedge clk); #1;
    slot_ok = 1'b1;
    @(posedge clk); #1;
    slot_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_we_in_wr", 32'(bus.mem_we), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_we_async_drop", 32'(bus.mem_we), 32'h0);
    check("t5_grant_in_rst", 32'(bus.cpu_grant), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_grant_after", 32'(bus.cpu_grant), 32'h1);
    check("t5_lost_cleared", 32'(lost), 32'h0);
    check("t5_ovf_idx_cleared", 32'(ovf_idx), 32'h0);
    cpu_rd(12'o0031, rd);
    check("t5_cell_unchanged", 32'(rd), 32'o00070);
    run_slot(gl, ih, ra);
    check("t5_pending_cleared", 32'(gl), 32'd0);

    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_counter_cycle_scheduler
